// File: rtl/psum_requant_buf.sv
// psum_requant_buf: accumulates conv_pe partial sums per column across input-channel tiles,
// then adds bias, round-shifts, ReLUs and int8-saturates into a show-ahead output FIFO.
// Build macro LEAKY_RELU_EN: negative ReLU inputs are scaled by 1/8 instead of zeroed.
`timescale 1ns/1ps
module psum_requant_buf #(
    parameter int TOUT   = 4,
    parameter int W_PSUM = 32,
    parameter int W_ACC  = 32,
    parameter int W_BIAS = 16,
    parameter int MAX_W  = 256,
    parameter int W_SIZE = 9,
    parameter int W_TILE = 8,
    parameter int FIFO_D = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   i_start,
    input  logic [W_SIZE-1:0]      cfg_width,
    input  logic [W_TILE-1:0]      cfg_ntile,
    input  logic [4:0]             cfg_shift,
    input  logic                   cfg_relu,
    input  logic [TOUT*W_BIAS-1:0] bias_flat,
    input  logic [TOUT*W_PSUM-1:0] i_acc,
    input  logic                   i_vld,
    output logic [TOUT*8-1:0]      o_data,
    output logic                   o_vld,
    input  logic                   i_rdy,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_ovf
);
    localparam int WS = W_ACC + 2;
    localparam int AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;
    localparam int FW = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
    localparam logic signed [WS-1:0] SMAX = WS'(127);
    localparam logic signed [WS-1:0] SMIN = WS'(-128);

    typedef enum logic [1:0] {IDLE, ACC, DRAIN} state_t;

    function automatic logic signed [WS-1:0] rnd_shift(input logic signed [WS-1:0] v,
                                                       input logic [4:0] sh);
        logic signed [WS-1:0] r;
        r = v;
        if (sh != 5'd0)
            r = (v + (WS'(1) <<< (sh - 5'd1))) >>> sh;
        return r;
    endfunction

    function automatic logic signed [WS-1:0] relu_fn(input logic signed [WS-1:0] v,
                                                     input logic en);
        logic signed [WS-1:0] r;
        r = v;
        if (en && v[WS-1]) begin
`ifdef LEAKY_RELU_EN
            r = v >>> 3;
`else
            r = '0;
`endif
        end
        return r;
    endfunction

    function automatic logic [7:0] sat8(input logic signed [WS-1:0] v);
        if (v > SMAX)
            return 8'h7F;
        else if (v < SMIN)
            return 8'h80;
        else
            return v[7:0];
    endfunction

    state_t                 state, state_nxt;
    logic [W_SIZE-1:0]      width_m1, col;
    logic [W_TILE-1:0]      ntile_m1, tile;
    logic [4:0]             shift_r;
    logic                   relu_r;
    logic [TOUT*W_BIAS-1:0] bias_r;
    logic                   beat, last_col, last_tile, start_ok;

    logic [TOUT*W_PSUM-1:0] acc_p0;
    logic [AW-1:0]          addr_p0;
    logic                   first_p0, last_p0, vld_p0;
    logic [TOUT*W_ACC-1:0]  lbuf [MAX_W];
    logic [TOUT*W_ACC-1:0]  rd_word, wr_word;
    logic [TOUT*8-1:0]      q_word, res_p1;
    logic                   vld_p1;

    logic [TOUT*8-1:0]      fifo_mem [FIFO_D];
    logic [FW:0]            wr_ptr, rd_ptr;
    logic                   fifo_empty, fifo_full, push, pop;

    assign beat      = (state == ACC) && i_vld;
    assign last_col  = (col == width_m1);
    assign last_tile = (tile == ntile_m1);
    assign start_ok  = (state == IDLE) && i_start;
    assign o_busy    = (state != IDLE);

    always_comb begin
        state_nxt = state;
        o_done    = 1'b0;
        case (state)
            IDLE:  if (i_start) state_nxt = ACC;
            ACC:   if (beat && last_col && last_tile) state_nxt = DRAIN;
            DRAIN: if (!vld_p0 && !vld_p1 && fifo_empty) begin
                o_done    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            col    <= '0;
            tile   <= '0;
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            state  <= state_nxt;
            vld_p0 <= beat;
            vld_p1 <= vld_p0 && last_p0;
            if (start_ok) begin
                col  <= '0;
                tile <= '0;
            end else if (beat) begin
                if (last_col) begin
                    col  <= '0;
                    tile <= tile + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    // zero-sized configs behave as a single column / tile
    always_ff @(posedge clk) begin
        if (start_ok) begin
            width_m1 <= (cfg_width == '0) ? '0 : cfg_width - 1'b1;
            ntile_m1 <= (cfg_ntile == '0) ? '0 : cfg_ntile - 1'b1;
            shift_r  <= cfg_shift;
            relu_r   <= cfg_relu;
            bias_r   <= bias_flat;
        end
    end

    // stage 0: capture beat, column address and tile position
    always_ff @(posedge clk) begin
        if (beat) begin
            acc_p0   <= i_acc;
            addr_p0  <= col[AW-1:0];
            first_p0 <= (tile == '0);
            last_p0  <= last_tile;
        end
    end

    assign rd_word = lbuf[addr_p0];

    for (genvar l = 0; l < TOUT; l++) begin : g_lane
        localparam int HI = TOUT - 1 - l;
        logic signed [W_PSUM-1:0] ps;
        logic signed [W_BIAS-1:0] bs;
        logic signed [W_ACC-1:0]  prev, psx, sum;
        logic signed [WS-1:0]     s;
        assign ps   = acc_p0[HI*W_PSUM +: W_PSUM];
        assign bs   = bias_r[HI*W_BIAS +: W_BIAS];
        assign prev = first_p0 ? '0 : rd_word[HI*W_ACC +: W_ACC];
        assign psx  = W_ACC'(ps);
        assign sum  = prev + psx;
        assign s    = WS'(prev) + WS'(psx) + WS'(bs);
        assign wr_word[HI*W_ACC +: W_ACC] = sum;
        assign q_word[HI*8 +: 8] = sat8(relu_fn(rnd_shift(s, shift_r), relu_r));
    end

    // stage 1: line-buffer write-back and registered requant result
    always_ff @(posedge clk) begin
        if (vld_p0) begin
            lbuf[addr_p0] <= wr_word;
            res_p1        <= q_word;
        end
    end

    // stage 2: push into the show-ahead FIFO
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[FW] != rd_ptr[FW]) && (wr_ptr[FW-1:0] == rd_ptr[FW-1:0]);
    assign o_vld      = !fifo_empty;
    assign pop        = o_vld && i_rdy;
    assign push       = vld_p1 && (!fifo_full || pop);
    assign o_data     = fifo_empty ? '0 : fifo_mem[rd_ptr[FW-1:0]];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            o_ovf  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (start_ok)
                o_ovf <= 1'b0;
            else if (vld_p1 && fifo_full && !pop)
                o_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[FW-1:0]] <= res_p1;
    end
endmodule

// File: tb/tb_psum_requant_buf.sv
// Directed testbench for psum_requant_buf: hand-computed vectors checked with immediate assertions.
`timescale 1ns/1ps
module tb_psum_requant_buf;
    logic        clk = 1'b0;
    logic        rstn;
    logic        i_start;
    logic [8:0]  cfg_width;
    logic [7:0]  cfg_ntile;
    logic [4:0]  cfg_shift;
    logic        cfg_relu;
    logic [63:0] bias_flat;
    logic [127:0] i_acc;
    logic        i_vld;
    logic [31:0] o_data;
    logic        o_vld;
    logic        i_rdy;
    logic        o_busy;
    logic        o_done;
    logic        o_ovf;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    logic [31:0] q[$];
    logic [31:0] exp3;

    psum_requant_buf dut (
        .clk(clk), .rstn(rstn), .i_start(i_start), .cfg_width(cfg_width),
        .cfg_ntile(cfg_ntile), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
        .bias_flat(bias_flat), .i_acc(i_acc), .i_vld(i_vld), .o_data(o_data),
        .o_vld(o_vld), .i_rdy(i_rdy), .o_busy(o_busy), .o_done(o_done), .o_ovf(o_ovf)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_vld && i_rdy) q.push_back(o_data);
        if (o_done) done_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic start_row(input int w, input int nt, input int sh, input bit relu,
                             input logic [63:0] bias);
        cfg_width = 9'(w);
        cfg_ntile = 8'(nt);
        cfg_shift = 5'(sh);
        cfg_relu  = relu;
        bias_flat = bias;
        i_start   = 1'b1;
        step();
        i_start   = 1'b0;
    endtask

    task automatic beat(input int a0, input int a1, input int a2, input int a3);
        i_acc = {32'(a0), 32'(a1), 32'(a2), 32'(a3)};
        i_vld = 1'b1;
        step();
    endtask

    task automatic wait_done(input string tag, input int exp_cnt);
        int n = 0;
        while (done_cnt < exp_cnt && n < 100) begin
            step();
            n++;
        end
        check(tag, 64'(done_cnt), 64'(exp_cnt));
    endtask

    initial begin
        rstn = 1'b0; i_start = 1'b0; cfg_width = '0; cfg_ntile = '0; cfg_shift = '0;
        cfg_relu = 1'b0; bias_flat = '0; i_acc = '0; i_vld = 1'b0; i_rdy = 1'b1;
        step();
        step();
        check("rst_vld",  64'(o_vld),  0);
        check("rst_busy", 64'(o_busy), 0);
        check("rst_done", 64'(o_done), 0);
        check("rst_ovf",  64'(o_ovf),  0);
        check("rst_data", 64'(o_data), 0);
        rstn = 1'b1;
        step();

        // single tile, saturating lanes, latency of two edges
        q.delete();
        start_row(4, 1, 0, 1'b0, 64'h0);
        beat(10, -5, 200, -300);
        check("t1_lat_e0", 64'(o_vld), 0);
        beat(10, -5, 200, -300);
        check("t1_lat_e1", 64'(o_vld), 0);
        beat(10, -5, 200, -300);
        check("t1_lat_e2", 64'(o_vld), 1);
        check("t1_data_ahead", 64'(o_data), 64'h0AFB7F80);
        beat(10, -5, 200, -300);
        i_vld = 1'b0;
        check("t1_busy", 64'(o_busy), 1);
        wait_done("t1_done", 1);
        check("t1_count", 64'(q.size()), 4);
        for (int i = 0; i < 4; i++) check("t1_word", 64'(q[i]), 64'h0AFB7F80);
        step();
        step();
        check("t1_single_done", 64'(done_cnt), 1);
        check("t1_idle", 64'(o_busy), 0);

        // three-tile accumulation with bias and rounding shift
        q.delete();
        start_row(2, 3, 2, 1'b0, {4{16'd2}});
        beat(100, 100, 100, 100);
        beat(100, 100, 100, 100);
        beat(50, 50, 50, 50);
        beat(50, 50, 50, 50);
        i_vld = 1'b0;
        step();
        step();
        check("t2_quiet_vld", 64'(o_vld), 0);
        check("t2_quiet_q", 64'(q.size()), 0);
        beat(-30, -30, -30, -30);
        beat(-30, -30, -30, -30);
        i_vld = 1'b0;
        wait_done("t2_done", 2);
        check("t2_count", 64'(q.size()), 2);
        check("t2_word0", 64'(q[0]), 64'h1F1F1F1F);
        check("t2_word1", 64'(q[1]), 64'h1F1F1F1F);

        // ReLU, positives untouched
        q.delete();
        start_row(1, 1, 0, 1'b1, 64'h0);
        beat(-40, 40, -40, 1000);
        i_vld = 1'b0;
        wait_done("t3_done", 3);
`ifdef LEAKY_RELU_EN
        exp3 = 32'hFB28FB7F;
`else
        exp3 = 32'h0028007F;
`endif
        check("t3_count", 64'(q.size()), 1);
        check("t3_word", 64'(q[0]), 64'(exp3));

        // backpressure: FIFO keeps first four, overflow flagged
        q.delete();
        i_rdy = 1'b0;
        start_row(8, 1, 0, 1'b0, 64'h0);
        for (int k = 0; k < 8; k++) beat(k, -k, k + 16, 100);
        i_vld = 1'b0;
        step();
        step();
        step();
        check("t4_ovf", 64'(o_ovf), 1);
        check("t4_vld", 64'(o_vld), 1);
        check("t4_busy", 64'(o_busy), 1);
        check("t4_no_done", 64'(done_cnt), 3);
        check("t4_head", 64'(o_data), 64'h00001064);
        i_rdy = 1'b1;
        wait_done("t4_done", 4);
        check("t4_count", 64'(q.size()), 4);
        check("t4_w0", 64'(q[0]), 64'h00001064);
        check("t4_w1", 64'(q[1]), 64'h01FF1164);
        check("t4_w2", 64'(q[2]), 64'h02FE1264);
        check("t4_w3", 64'(q[3]), 64'h03FD1364);
        check("t4_ovf_sticky", 64'(o_ovf), 1);

        // reset mid-row aborts without o_done
        i_rdy = 1'b0;
        start_row(8, 1, 0, 1'b0, 64'h0);
        check("t5_ovf_cleared", 64'(o_ovf), 0);
        beat(1, 1, 1, 1);
        beat(1, 1, 1, 1);
        beat(1, 1, 1, 1);
        i_vld = 1'b0;
        check("t5_pre_vld", 64'(o_vld), 1);
        rstn = 1'b0;
        #1;
        check("t5_rst_busy", 64'(o_busy), 0);
        check("t5_rst_vld", 64'(o_vld), 0);
        check("t5_rst_data", 64'(o_data), 0);
        step();
        rstn = 1'b1;
        step();
        step();
        step();
        check("t5_no_done", 64'(done_cnt), 4);
        q.delete();
        i_rdy = 1'b1;
        start_row(2, 1, 1, 1'b0, {16'h0001, 16'hFFFF, 16'h0000, 16'h0005});
        beat(7, -7, 255, -256);
        beat(0, 0, 0, 0);
        i_vld = 1'b0;
        wait_done("t5_done", 5);
        check("t5_count", 64'(q.size()), 2);
        check("t5_w0", 64'(q[0]), 64'h04FC7F83);
        check("t5_w1", 64'(q[1]), 64'h01000003);

        // i_start while busy is ignored
        q.delete();
        start_row(3, 1, 0, 1'b0, 64'h0);
        beat(1, 2, 3, 4);
        i_start = 1'b1; cfg_width = 9'd1; cfg_shift = 5'd3; cfg_relu = 1'b1;
        bias_flat = {4{16'd100}};
        beat(5, 6, 7, 8);
        i_start = 1'b0;
        beat(9, 10, 11, 12);
        i_vld = 1'b0;
        wait_done("t6_done", 6);
        check("t6_count", 64'(q.size()), 3);
        check("t6_w0", 64'(q[0]), 64'h01020304);
        check("t6_w1", 64'(q[1]), 64'h05060708);
        check("t6_w2", 64'(q[2]), 64'h090A0B0C);
        step();
        step();
        check("t6_single_done", 64'(done_cnt), 6);
        check("t6_idle", 64'(o_busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
